// File: rtl/pi_rgb_pkg.sv
// Shared types and constants for the Pi RGB PWM scheduler: phases, write
// select layout and colour codes.
package pi_rgb_pkg;

  localparam int unsigned DUTY_W_DEF = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned NUM_LEDS   = 2;
  localparam int unsigned NUM_COLS   = 3;

  localparam logic [1:0] COL_R   = 2'd0;
  localparam logic [1:0] COL_G   = 2'd1;
  localparam logic [1:0] COL_B   = 2'd2;
  localparam logic [1:0] COL_BAD = 2'd3;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  // Write select payload: led in the MSB, colour code below it
  typedef struct packed {
    logic       led;
    logic [1:0] col;
  } sel_t;

  function automatic logic col_valid(input logic [1:0] col);
    return col != COL_BAD;
  endfunction

endpackage

// File: rtl/pi_pwm_timebase.sv
// PWM timebase: prescaler, PWM counter, colour phase FSM, commit strobe and
// frame_start pulse.
module pi_pwm_timebase
  import pi_rgb_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned DUTY_W   = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  output phase_e            phase_o,
  output logic [DUTY_W-1:0] pwm_cnt_o,
  output logic              commit_c,
  output logic              frame_start_o
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_MAX  = PS_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CNT_MAX = {{(DUTY_W-1){1'b1}}, 1'b0};

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  phase_e            phase_q, phase_d;
  logic              fs_q, fs_d;
  logic              tick_c;
  logic              cnt_max_c;

  assign tick_c    = enable_i & (presc_q == PS_MAX);
  assign cnt_max_c = (cnt_q == CNT_MAX);
  assign commit_c  = tick_c & cnt_max_c & (phase_q == PH_B);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      phase_q <= PH_R;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      fs_q    <= fs_d;
    end
  end

  // Everything holds while disabled; the phase only moves at the end of a PWM period
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    fs_d    = commit_c;
    if (tick_c) begin
      presc_d = '0;
      if (cnt_max_c) begin
        cnt_d = '0;
        case (phase_q)
          PH_R:    phase_d = PH_G;
          PH_G:    phase_d = PH_B;
          PH_B:    phase_d = PH_R;
          default: phase_d = PH_R;
        endcase
      end else begin
        cnt_d = cnt_q + DUTY_W'(1);
      end
    end else if (enable_i) begin
      presc_d = presc_q + PS_W'(1);
    end
  end

  assign phase_o       = phase_q;
  assign pwm_cnt_o     = cnt_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/pi_rgb_pwm_scheduler.sv
// Time-division RGB PWM for LED16/LED17: staged duty writes that commit at
// frame boundaries, one colour lit per LED at a time.
module pi_rgb_pwm_scheduler
  import pi_rgb_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned DUTY_W   = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic              wr_err,
  output logic              led16_r,
  output logic              led16_g,
  output logic              led16_b,
  output logic              led17_r,
  output logic              led17_g,
  output logic              led17_b,
  output logic              frame_start
);

  localparam int unsigned NUM_OUT = NUM_LEDS * NUM_COLS;

  phase_e            phase;
  logic [DUTY_W-1:0] pwm_cnt;
  logic              commit_c;

  logic [DUTY_W-1:0] pend_q [NUM_LEDS][NUM_COLS];
  logic [DUTY_W-1:0] pend_d [NUM_LEDS][NUM_COLS];
  logic [DUTY_W-1:0] act_q  [NUM_LEDS][NUM_COLS];
  logic [DUTY_W-1:0] act_d  [NUM_LEDS][NUM_COLS];
  logic [NUM_OUT-1:0] led_q, led_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_fire;
  sel_t              sel;

  pi_pwm_timebase #(
    .PRESCALE (PRESCALE),
    .DUTY_W   (DUTY_W)
  ) u_timebase (
    .clk           (clk),
    .reset         (reset),
    .enable_i      (enable),
    .phase_o       (phase),
    .pwm_cnt_o     (pwm_cnt),
    .commit_c      (commit_c),
    .frame_start_o (frame_start)
  );

  assign sel = sel_t'(wr_sel);

  // Writes stall during the commit cycle so they cannot race the bank copy
  assign wr_ready = ~reset & ~commit_c;
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    pend_d   = pend_q;
    act_d    = act_q;
    wr_err_d = wr_fire & ~col_valid(sel.col);
    if (commit_c) begin
      act_d = pend_q;
    end
    if (wr_fire && col_valid(sel.col)) begin
      pend_d[sel.led][sel.col] = wr_duty;
    end
  end

  // Output index is led*3 + colour; phase codes match colour codes
  always_comb begin
    led_d = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        led_d[n*NUM_COLS + c] = enable & (2'(phase) == 2'(c)) & (pwm_cnt < act_q[n][c]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_LEDS; n++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          pend_q[n][c] <= '0;
          act_q[n][c]  <= '0;
        end
      end
      led_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      act_q    <= act_d;
      led_q    <= led_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_err  = wr_err_q;
  assign led16_r = led_q[0];
  assign led16_g = led_q[1];
  assign led16_b = led_q[2];
  assign led17_r = led_q[3];
  assign led17_g = led_q[4];
  assign led17_b = led_q[5];

endmodule

// File: tb/tb_pi_rgb_pwm_scheduler.sv
// Directed bench for pi_rgb_pwm_scheduler at PRESCALE=1 (765-cycle frames).
module tb_pi_rgb_pwm_scheduler;

  localparam int FRAME = 765;
  localparam int PAUSE = 50;

  logic       clk = 1'b0;
  logic       reset, enable, wr_valid, wr_ready, wr_err, frame_start;
  logic [2:0] wr_sel;
  logic [7:0] wr_duty;
  logic       led16_r, led16_g, led16_b, led17_r, led17_g, led17_b;

  int n_chk, n_pass;
  int lit [6];
  int ready_lo, accepts, errs, fs_cnt, fs_last, overlap, pause_lit;

  always #5 clk = ~clk;

  pi_rgb_pwm_scheduler #(.PRESCALE(1), .DUTY_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_sel      (wr_sel),
    .wr_duty     (wr_duty),
    .wr_err      (wr_err),
    .led16_r     (led16_r),
    .led16_g     (led16_g),
    .led16_b     (led16_b),
    .led17_r     (led17_r),
    .led17_g     (led17_g),
    .led17_b     (led17_b),
    .frame_start (frame_start)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic logic [5:0] leds();
    return {led17_b, led17_g, led17_r, led16_b, led16_g, led16_r};
  endfunction

  // Accept one write starting from the current (post-negedge) time
  task automatic write(input logic [2:0] sel, input logic [7:0] duty);
    logic acc;
    acc      = 1'b0;
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_duty  = duty;
    for (int t = 0; t < 10; t++) begin
      acc = wr_ready;
      @(negedge clk);
      if (acc) break;
    end
    wr_valid = 1'b0;
    #1;
    check($sformatf("write_accept sel=%0d", sel), int'(acc), 1);
  endtask

  task automatic wait_fs(output int cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #1;
      cycles++;
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    check("frame_start_seen", int'(found), 1);
  endtask

  // Starts on a frame_start sample; samples len cycles, the last of which
  // must be the next frame_start. Outputs lag state by one cycle.
  task automatic run_frame(input int len, input int wr_on, input int wr_off,
                           input logic [2:0] sel, input logic [7:0] duty,
                           input int pause_at);
    logic [5:0] l;
    for (int k = 0; k < 6; k++) lit[k] = 0;
    ready_lo = 0; accepts = 0; errs = 0; fs_cnt = 0; overlap = 0; pause_lit = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      wr_valid = (i >= wr_on) && (i < wr_off);
      wr_sel   = sel;
      wr_duty  = duty;
      enable   = !((pause_at >= 0) && (i >= pause_at) && (i < pause_at + PAUSE));
      #1;
      l = leds();
      for (int k = 0; k < 6; k++) lit[k] += int'(l[k]);
      if ($countones(l[2:0]) > 1 || $countones(l[5:3]) > 1) overlap++;
      if (!wr_ready) ready_lo++;
      if (wr_valid && wr_ready) accepts++;
      errs   += int'(wr_err);
      fs_cnt += int'(frame_start);
      if (pause_at >= 0 && i > pause_at && i <= pause_at + PAUSE && l != 6'd0) pause_lit++;
    end
    fs_last = int'(frame_start);
  endtask

  task automatic check_frame(input string f, input int e16r, input int e16g, input int e16b,
                             input int e17r, input int e17g, input int e17b,
                             input int eacc, input int eerr);
    check({f, " led16_r"}, lit[0], e16r);
    check({f, " led16_g"}, lit[1], e16g);
    check({f, " led16_b"}, lit[2], e16b);
    check({f, " led17_r"}, lit[3], e17r);
    check({f, " led17_g"}, lit[4], e17g);
    check({f, " led17_b"}, lit[5], e17b);
    check({f, " colour_overlap"}, overlap, 0);
    check({f, " ready_low_cycles"}, ready_lo, 1);
    check({f, " accepts"}, accepts, eacc);
    check({f, " wr_err_pulses"}, errs, eerr);
    check({f, " frame_start_count"}, fs_cnt, 1);
    check({f, " frame_start_at_end"}, fs_last, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; enable = 1'b1; wr_valid = 1'b0; wr_sel = 3'd0; wr_duty = 8'd0;

    repeat (3) @(negedge clk);
    #1;
    check("reset wr_ready", int'(wr_ready), 0);
    check("reset leds", int'(leds()), 0);
    check("reset frame_start", int'(frame_start), 0);
    check("reset wr_err", int'(wr_err), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wr_ready after reset", int'(wr_ready), 1);

    // Basic duties, then a mid-PH_R write that must not tear
    write(3'b000, 8'd128);
    write(3'b110, 8'd255);
    wait_fs(cyc);
    run_frame(FRAME, 50, 51, 3'b001, 8'd10, -1);
    check_frame("f1", 128, 0, 0, 0, 0, 255, 1, 0);

    // Write held across the commit cycle: accepted one cycle late
    run_frame(FRAME, FRAME - 1, FRAME + 1, 3'b100, 8'd200, -1);
    check_frame("f2", 128, 10, 0, 0, 0, 255, 1, 0);

    // Colour 3 write: error pulse, banks untouched
    run_frame(FRAME, 100, 101, 3'b011, 8'd77, -1);
    check_frame("f3", 128, 10, 0, 0, 0, 255, 1, 1);

    // Pause at PH_G pwm_cnt=5 for 50 cycles
    run_frame(FRAME + PAUSE, 0, 0, 3'b000, 8'd0, 260);
    check_frame("f4", 128, 10, 0, 200, 0, 255, 0, 0);
    check("f4 lit during pause", pause_lit, 0);

    // Reset in PH_B with a pending write outstanding
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      wr_valid = (i == 20);
      wr_sel   = 3'b010;
      wr_duty  = 8'd99;
    end
    reset = 1'b1;
    #1;
    check("mid reset wr_ready", int'(wr_ready), 0);
    @(negedge clk);
    #1;
    check("mid reset leds", int'(leds()), 0);
    check("mid reset frame_start", int'(frame_start), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wr_ready after mid reset", int'(wr_ready), 1);
    wait_fs(cyc);
    check("cycles reset to frame_start", cyc, FRAME);
    run_frame(FRAME, 0, 0, 3'b000, 8'd0, -1);
    check_frame("f5", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
